aes256_dec_key_stream: RTL and testbench
========================================

Name: aes256_dec_key_stream

Overview:
- Generates the AES-256 decryption round-key stream: round keys 14 down to 0, one 128-bit key per handshake.
- Accepts the 256-bit cipher key and runs the team's forward schedule sequentially to round key 14. It then walks the schedule backwards with the inverse word transform.
- Feeds the decryption round pipeline. No 1920-bit key store is needed.

Parameters:
EQ_INV, 0, 1 = apply InvMixColumns to emitted keys with index 1..13 (equivalent inverse cipher); 0 = emit raw keys.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active-low
key_valid  in  1  cipher key offered
key_ready  out  1  block idle, key accepted this cycle when key_valid=1
key_in  in  256  cipher key
rk_valid  out  1  round key valid
rk_ready  in  1  consumer accepts round key
rk_data  out  128  round key
rk_index  out  4  round number of rk_data, 14..0
rk_last  out  1  high with rk_index=0
busy  out  1  not IDLE

Behaviour:
- Key definition:
  - k[0]=key_in[255:128], k[1]=key_in[127:0].
  - k[i+2]=F(k[i+1],i) for i=0..12.
- F(K,r):
  - Words w0..w3 = K[127:96]..K[31:0].
  - t = SubWord({w3[23:0],w3[31:24]}), using the standard AES S-box per byte via the team's 32-bit subBytes block.
  - w0'=w0^t^RCON(r); w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'.
- RCON(r), r=0..12, top byte; lower 24 bits zero: 01,02,04,08,10,20,40,80,1b,36,6c,d8,ab.
- Inverse G(K',r):
  - w3=w3'^w2'; w2=w2'^w1'; w1=w1'^w0'.
  - w0=w0'^SubWord({w3[23:0],w3[31:24]})^RCON(r).
- Registers: cur[127:0], k0[127:0], rnd[3:0], idx[3:0], state.
- FSM IDLE:
  - key_ready=1.
  - On key_valid: cur<=key_in[127:0], k0<=key_in[255:128], rnd<=0, go to EXPAND.
- FSM EXPAND:
  - Each cycle: cur<=F(cur,rnd), rnd<=rnd+1.
  - After the rnd=12 step (13 cycles): idx<=14, go to EMIT.
- FSM EMIT:
  - rk_valid=1; rk_index=idx.
  - rk_data = k0 when idx=0, otherwise cur. When EQ_INV=1 and 1<=idx<=13, rk_data is InvMixColumns of that value.
  - On rk_valid&&rk_ready:
    - idx>=2: cur<=G(cur,idx-2), idx<=idx-1.
    - idx=1: idx<=0.
    - idx=0: go to IDLE.
- Latency: key accepted in cycle T gives the first rk_valid in cycle T+14. Back-to-back rk_ready gives 15 consecutive keys.
- Stability: rk_data, rk_index and rk_last stay stable while rk_valid&&!rk_ready.
- key_ready=0 in EXPAND and EMIT; key_valid is ignored there. A new key may be accepted the cycle after the idx=0 handshake.
- rk_ready is ignored outside EMIT.
- Reset values (asynchronous, any state, including mid-EXPAND or mid-EMIT):
  - Outputs: key_ready=1, rk_valid=0, rk_data=0, rk_index=0, rk_last=0, busy=0.
  - Registers: cur=0, k0=0, rnd=0, idx=0, state=IDLE.
  - The partial stream is discarded.
- Arithmetic: all 4-bit counters; no wrap occurs in legal operation (rnd stops at 12, idx stops at 0).

Test Plan:
- key_in=0, rk_ready=1 -> first rk_valid 14 cycles after accept. Check these emitted values:
  - idx 11 = b4ef5bcb3e92e21123e951cf6f8f188e.
  - idx 2 = 62636363 repeated 4 times.
  - idx 1 = 0; idx 0 = 0 with rk_last=1.
- Random key, EQ_INV=0 -> the 15 emitted keys equal the reference model's forward k[14..0] in reverse order; rk_index counts 14..0.
- rk_ready toggled pseudo-randomly (30% low) -> no key lost or duplicated; rk_data held while stalled; key_valid asserted during EMIT is not accepted.
- EQ_INV=1, same key as scenario 2 -> idx 14 and 0 raw; idx 1..13 equal InvMixColumns(model key).
- rst_n pulsed low at EXPAND cycle 5, and separately at EMIT idx=7 -> outputs go to reset values immediately. A fresh key afterwards streams correctly from idx 14.
- Two keys back-to-back -> second accepted the cycle after the first rk_last handshake; second stream is correct.

Source files
------------

// File: rtl/aes256_dec_key_stream.sv
// AES-256 decryption round-key stream: keys 14..0, one per rk handshake.
// Ports: key_valid/key_ready/key_in in; rk_valid/rk_ready/rk_data/rk_index/rk_last out; busy.
module aes256_dec_key_stream #(
    parameter logic EQ_INV = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [255:0] key_in,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_data,
    output logic [3:0]   rk_index,
    output logic         rk_last,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, EXPAND, EMIT} state_e;

    state_e       state_q, state_d;
    logic [127:0] cur_q, cur_d;
    logic [127:0] k0_q, k0_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [3:0]   idx_q, idx_d;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (a^254) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] a2, a3, a12, a15, a240, v;
        a2   = gmul(a, a);
        a3   = gmul(a2, a);
        a12  = gmul(gmul(a3, a3), gmul(a3, a3));
        a15  = gmul(a12, a3);
        a240 = gmul(a15, a15);
        a240 = gmul(a240, a240);
        a240 = gmul(a240, a240);
        a240 = gmul(a240, a240);
        v    = gmul(gmul(a240, a12), a2);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]}
                 ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] rcon(input logic [3:0] r);
        logic [7:0] c;
        unique case (r)
            4'd0:    c = 8'h01;
            4'd1:    c = 8'h02;
            4'd2:    c = 8'h04;
            4'd3:    c = 8'h08;
            4'd4:    c = 8'h10;
            4'd5:    c = 8'h20;
            4'd6:    c = 8'h40;
            4'd7:    c = 8'h80;
            4'd8:    c = 8'h1b;
            4'd9:    c = 8'h36;
            4'd10:   c = 8'h6c;
            4'd11:   c = 8'hd8;
            4'd12:   c = 8'hab;
            default: c = 8'h00;
        endcase
        return {c, 24'h0};
    endfunction

    function automatic logic [31:0] imc_col(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        a0 = w[31:24];
        a1 = w[23:16];
        a2 = w[15:8];
        a3 = w[7:0];
        return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
                gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
    endfunction

    logic [31:0]  w0, w1, w2, w3, sub_in, t, rc;
    logic [3:0]   rc_sel;
    logic [127:0] f_key, g_key, raw_key;
    logic         emit;

    assign w0 = cur_q[127:96];
    assign w1 = cur_q[95:64];
    assign w2 = cur_q[63:32];
    assign w3 = cur_q[31:0];

    // One SubWord serves both directions: going backwards, the w3 it
    // needs is the recovered previous-key word w3'^w2'.
    assign emit   = (state_q == EMIT);
    assign sub_in = emit ? (w3 ^ w2) : w3;
    assign t      = sub_word({sub_in[23:0], sub_in[31:24]});
    assign rc_sel = emit ? (idx_q - 4'd2) : rnd_q;
    assign rc     = rcon(rc_sel);

    always_comb begin
        logic [31:0] f0, f1, f2;
        f0    = w0 ^ t ^ rc;
        f1    = w1 ^ f0;
        f2    = w2 ^ f1;
        f_key = {f0, f1, f2, w3 ^ f2};
        g_key = {w0 ^ t ^ rc, w1 ^ w0, w2 ^ w1, w3 ^ w2};
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        k0_d    = k0_q;
        rnd_d   = rnd_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (key_valid) begin
                    cur_d   = key_in[127:0];
                    k0_d    = key_in[255:128];
                    rnd_d   = 4'd0;
                    state_d = EXPAND;
                end
            end
            EXPAND: begin
                cur_d = f_key;
                if (rnd_q == 4'd12) begin
                    idx_d   = 4'd14;
                    state_d = EMIT;
                end else begin
                    rnd_d = rnd_q + 4'd1;
                end
            end
            EMIT: begin
                if (rk_ready) begin
                    if (idx_q >= 4'd2) begin
                        cur_d = g_key;
                        idx_d = idx_q - 4'd1;
                    end else if (idx_q == 4'd1) begin
                        idx_d = 4'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cur_q   <= '0;
            k0_q    <= '0;
            rnd_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            k0_q    <= k0_d;
            rnd_q   <= rnd_d;
            idx_q   <= idx_d;
        end
    end

    assign raw_key = (idx_q == 4'd0) ? k0_q : cur_q;

    always_comb begin
        rk_data = '0;
        if (emit) begin
            if (EQ_INV && idx_q != 4'd0 && idx_q != 4'd14) begin
                rk_data = {imc_col(raw_key[127:96]), imc_col(raw_key[95:64]),
                           imc_col(raw_key[63:32]), imc_col(raw_key[31:0])};
            end else begin
                rk_data = raw_key;
            end
        end
    end

    assign key_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign rk_valid  = emit;
    assign rk_index  = emit ? idx_q : 4'd0;
    assign rk_last   = emit && (idx_q == 4'd0);

endmodule

// File: tb/tb_aes256_dec_key_stream.sv
// Bench for aes256_dec_key_stream: raw and equivalent-inverse instances
// side by side, checked against a forward schedule model.
module tb_aes256_dec_key_stream;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         key_valid;
    logic [255:0] key_in;
    logic         rk_ready;

    logic         key_ready, rk_valid, rk_last, busy;
    logic [127:0] rk_data;
    logic [3:0]   rk_index;
    logic         key_ready_e, rk_valid_e, rk_last_e, busy_e;
    logic [127:0] rk_data_e;
    logic [3:0]   rk_index_e;

    aes256_dec_key_stream #(.EQ_INV(1'b0)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .key_valid(key_valid), .key_ready(key_ready), .key_in(key_in),
        .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_data(rk_data),
        .rk_index(rk_index), .rk_last(rk_last), .busy(busy)
    );

    aes256_dec_key_stream #(.EQ_INV(1'b1)) u_dut_eq (
        .clk(clk), .rst_n(rst_n),
        .key_valid(key_valid), .key_ready(key_ready_e), .key_in(key_in),
        .rk_valid(rk_valid_e), .rk_ready(rk_ready), .rk_data(rk_data_e),
        .rk_index(rk_index_e), .rk_last(rk_last_e), .busy(busy_e)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] sbox_ref(input logic [7:0] b);
        logic [127:0] r;
        int col;
        case (b[7:4])
            4'h0: r = 128'h637c777bf26b6fc53001672bfed7ab76;
            4'h1: r = 128'hca82c97dfa5947f0add4a2af9ca472c0;
            4'h2: r = 128'hb7fd9326363ff7cc34a5e5f171d83115;
            4'h3: r = 128'h04c723c31896059a071280e2eb27b275;
            4'h4: r = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
            4'h5: r = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
            4'h6: r = 128'hd0efaafb434d338545f9027f503c9fa8;
            4'h7: r = 128'h51a3408f929d38f5bcb6da2110fff3d2;
            4'h8: r = 128'hcd0c13ec5f974417c4a77e3d645d1973;
            4'h9: r = 128'h60814fdc222a908846eeb814de5e0bdb;
            4'ha: r = 128'he0323a0a4906245cc2d3ac629195e479;
            4'hb: r = 128'he7c8376d8dd54ea96c56f4ea657aae08;
            4'hc: r = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
            4'hd: r = 128'h703eb5664803f60e613557b986c11d9e;
            4'he: r = 128'he1f8981169d98e949b1e87e9ce5528df;
            default: r = 128'h8ca1890dbfe6426841992d0fb054bb16;
        endcase
        col = int'(b[3:0]);
        return r[8*(15-col) +: 8];
    endfunction

    function automatic logic [127:0] f_ref(input logic [127:0] k, input int r);
        logic [7:0]  rcon_tab [13];
        logic [31:0] w0, w1, w2, w3, rot, t;
        rcon_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                     8'h80, 8'h1b, 8'h36, 8'h6c, 8'hd8, 8'hab};
        w3  = k[31:0];
        rot = {w3[23:0], w3[31:24]};
        t   = {sbox_ref(rot[31:24]), sbox_ref(rot[23:16]),
               sbox_ref(rot[15:8]), sbox_ref(rot[7:0])};
        w0  = k[127:96] ^ t ^ {rcon_tab[r], 24'h0};
        w1  = k[95:64] ^ w0;
        w2  = k[63:32] ^ w1;
        w3  = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Forward MixColumns undoes the DUT's InvMixColumns.
    function automatic logic [127:0] mixcol(input logic [127:0] k);
        logic [127:0] o;
        for (int c = 0; c < 4; c++) begin
            logic [7:0] a0, a1, a2, a3;
            a0 = k[127-32*c -: 8];
            a1 = k[119-32*c -: 8];
            a2 = k[111-32*c -: 8];
            a3 = k[103-32*c -: 8];
            o[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            o[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
        return o;
    endfunction

    logic [127:0] exp_k [15];
    logic [127:0] got_k [15];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        #2;
        key_valid = 1'b0;
        rst_n     = 1'b0;
        #1;
        check("rst_key_ready", 128'(key_ready), 128'd1);
        check("rst_rk_valid", 128'(rk_valid), 128'd0);
        check("rst_rk_data", rk_data, 128'd0);
        check("rst_rk_data_eq", rk_data_e, 128'd0);
        check("rst_rk_index", 128'(rk_index), 128'd0);
        check("rst_rk_last", 128'(rk_last), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        #3;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic run_stream(input logic [255:0] key, input bit stall,
                              input int abort_exp, input int abort_emit,
                              input bit junk_valid);
        int lat;
        int e;
        int cyc;
        bit done;
        bit rdy;
        exp_k[0] = key[255:128];
        exp_k[1] = key[127:0];
        for (int i = 0; i <= 12; i++) exp_k[i+2] = f_ref(exp_k[i+1], i);
        check("accept_ready", 128'(key_ready), 128'd1);
        key_valid = 1'b1;
        key_in    = key;
        tick();
        key_valid = junk_valid;
        key_in    = ~key;
        lat = 1;
        while (!rk_valid && lat < 40) begin
            check("expand_busy", 128'(busy), 128'd1);
            check("expand_key_ready", 128'(key_ready), 128'd0);
            if (abort_exp > 0 && lat == abort_exp) begin
                pulse_reset();
                return;
            end
            tick();
            lat++;
        end
        check("first_latency", 128'(lat), 128'd14);
        if (!rk_valid) begin
            key_valid = 1'b0;
            return;
        end
        e    = 14;
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 300) begin
            check("rk_valid", 128'(rk_valid), 128'd1);
            check("rk_index", 128'(rk_index), 128'(e));
            check("rk_data", rk_data, exp_k[e]);
            check("rk_last", 128'(rk_last), 128'(e == 0));
            check("emit_key_ready", 128'(key_ready), 128'd0);
            if (e == 0 || e == 14)
                check("eq_raw", rk_data_e, exp_k[e]);
            else
                check("eq_imc", mixcol(rk_data_e), exp_k[e]);
            if (abort_emit >= 0 && e == abort_emit) begin
                pulse_reset();
                return;
            end
            rdy      = stall ? ($urandom_range(0, 99) >= 30) : 1'b1;
            rk_ready = rdy;
            if (rdy) begin
                got_k[e] = rk_data;
                if (e == 0) begin
                    key_valid = 1'b0;
                    done      = 1'b1;
                end else begin
                    e--;
                end
            end
            tick();
            cyc++;
        end
        rk_ready = 1'b1;
        check("stream_done", 128'(done), 128'd1);
    endtask

    logic [255:0] key_a, key_b;

    initial begin
        rst_n     = 1'b0;
        key_valid = 1'b0;
        key_in    = '0;
        rk_ready  = 1'b1;
        #12;
        check("init_key_ready", 128'(key_ready), 128'd1);
        check("init_rk_valid", 128'(rk_valid), 128'd0);
        check("init_rk_data", rk_data, 128'd0);
        check("init_busy", 128'(busy), 128'd0);
        #4;
        rst_n = 1'b1;
        tick();

        run_stream(256'd0, 1'b0, 0, -1, 1'b0);
        check("zero_idx11", got_k[11], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
        check("zero_idx2", got_k[2], {4{32'h62636363}});
        check("zero_idx1", got_k[1], 128'd0);
        check("zero_idx0", got_k[0], 128'd0);

        for (int i = 0; i < 8; i++) key_a[32*i +: 32] = $urandom;
        for (int i = 0; i < 8; i++) key_b[32*i +: 32] = $urandom;

        run_stream(key_a, 1'b0, 0, -1, 1'b0);
        run_stream(key_b, 1'b1, 0, -1, 1'b1);
        run_stream(key_a, 1'b0, 5, -1, 1'b0);
        run_stream(key_b, 1'b0, 0, -1, 1'b0);
        run_stream(key_b, 1'b0, 0, 7, 1'b0);
        run_stream(key_a, 1'b0, 0, -1, 1'b0);
        run_stream(key_b, 1'b0, 0, -1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
